// File: rtl/fabric_pkg.sv
// rtl/fabric_pkg.sv - fabric-wide instruction field widths shared by row-facing blocks
package fabric_pkg;
    localparam int INSTR_DATA_WIDTH = 32;
    localparam int INSTR_ADDR_WIDTH = 6;
    localparam int INSTR_HOPS_WIDTH = 4;
endpackage

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - state encoding and buffered instruction word for instr_loader
package instr_loader_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        CALL      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    // One instruction as it travels down the row chain.
    typedef struct packed {
        logic [fabric_pkg::INSTR_DATA_WIDTH-1:0] data;
        logic [fabric_pkg::INSTR_ADDR_WIDTH-1:0] addr;
        logic [fabric_pkg::INSTR_HOPS_WIDTH-1:0] hops;
    } instr_t;
endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - host push bus into the instruction loader
interface instr_loader_if #(
    parameter int DATA_W = fabric_pkg::INSTR_DATA_WIDTH,
    parameter int ADDR_W = fabric_pkg::INSTR_ADDR_WIDTH,
    parameter int HOPS_W = fabric_pkg::INSTR_HOPS_WIDTH
);
    logic              host_valid;
    logic              host_ready;
    logic [DATA_W-1:0] host_data;
    logic [ADDR_W-1:0] host_addr;
    logic [HOPS_W-1:0] host_hops;

    // Host logic side: offers words.
    modport master (
        output host_valid, host_data, host_addr, host_hops,
        input  host_ready
    );

    // Loader side: accepts words.
    modport slave (
        input  host_valid, host_data, host_addr, host_hops,
        output host_ready
    );
endinterface

// File: rtl/instr_loader_fifo.sv
// rtl/instr_loader_fifo.sv - single-clock FIFO of instruction words with occupancy count
module instr_fifo
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  instr_t                   push_data_i,
    input  logic                     pop_i,
    output instr_t                   pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    instr_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;

    // The extra pointer bit makes wr-rd the exact occupancy, so full and empty never alias.
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = (count_o == (AW+1)'(DEPTH));
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; pushes when full and pops when empty are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i && !full_o)
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - buffers host instructions, streams them to a fabric row, then runs call/ret
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int INSTR_DATA_WIDTH = fabric_pkg::INSTR_DATA_WIDTH,
    parameter int INSTR_ADDR_WIDTH = fabric_pkg::INSTR_ADDR_WIDTH,
    parameter int INSTR_HOPS_WIDTH = fabric_pkg::INSTR_HOPS_WIDTH,
    parameter int FIFO_DEPTH       = 16,
    parameter int RET_TIMEOUT      = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instr_loader_if.slave               host,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [$clog2(FIFO_DEPTH):0] fill,
    output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
    output logic                        instr_en_out,
    output logic                        call,
    input  logic                        ret
);
    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W  = $clog2(RET_TIMEOUT + 1);

    state_t             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic               call_q;
    logic               done_q;
    logic               timeout_q;
    logic               instr_en_q;
    instr_t             instr_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [FILL_W-1:0]  fifo_count;
    instr_t             fifo_head;
    instr_t             host_word;
    logic               push;
    logic               pop;

    assign host.host_ready = (state_q == IDLE) && !fifo_full;
    assign busy            = (state_q != IDLE);
    assign push            = host.host_valid && host.host_ready;
    assign pop             = (state_q == SEND) && !fifo_empty;
    assign host_word       = '{data: host.host_data, addr: host.host_addr, hops: host.host_hops};

    instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (host_word),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Launch FSM: stream the frozen batch, pulse call, then follow ret low-then-high or time out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            call_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            instr_en_q <= 1'b0;
            instr_q    <= '0;
        end else begin
            call_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            instr_en_q <= 1'b0;
            instr_q    <= '0;
            case (state_q)
                IDLE: begin
                    // A word pushed in the start cycle belongs to this batch.
                    if (start)
                        state_q <= (!fifo_empty || push) ? SEND : CALL;
                end
                SEND: begin
                    instr_en_q <= !fifo_empty;
                    instr_q    <= fifo_empty ? '0 : fifo_head;
                    if (fifo_count <= FILL_W'(1))
                        state_q <= CALL;
                end
                CALL: begin
                    call_q  <= 1'b1;
                    timer_q <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!ret) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == TMR_W'(RET_TIMEOUT)) begin
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (ret) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fill           = fifo_count;
    assign call           = call_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign instr_en_out   = instr_en_q;
    assign instr_data_out = instr_q.data;
    assign instr_addr_out = instr_q.addr;
    assign instr_hops_out = instr_q.hops;
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;
    localparam int RET_TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [4:0]  fill;
    logic [31:0] instr_data_out;
    logic [5:0]  instr_addr_out;
    logic [3:0]  instr_hops_out;
    logic        instr_en_out;
    logic        call;
    logic        ret;

    int checks = 0;
    int errors = 0;

    instr_loader_if hif ();

    instr_loader #(
        .FIFO_DEPTH  (16),
        .RET_TIMEOUT (RET_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host           (hif),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .fill           (fill),
        .instr_data_out (instr_data_out),
        .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out),
        .instr_en_out   (instr_en_out),
        .call           (call),
        .ret            (ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land mid-cycle, where registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] d, input logic [5:0] a, input logic [3:0] h);
        hif.host_valid = 1'b1;
        hif.host_data  = d;
        hif.host_addr  = a;
        hif.host_hops  = h;
        tick();
        hif.host_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [5:0] a,
                               input logic [3:0] h);
        chk({tag, "_en"},   instr_en_out,   1'b1);
        chk({tag, "_data"}, instr_data_out, d);
        chk({tag, "_addr"}, instr_addr_out, a);
        chk({tag, "_hops"}, instr_hops_out, h);
        chk({tag, "_call"}, call,           1'b0);
    endtask

    task automatic expect_call(input string tag);
        chk({tag, "_call"}, call,           1'b1);
        chk({tag, "_en"},   instr_en_out,   1'b0);
        chk({tag, "_data0"}, instr_data_out, 32'h0);
    endtask

    // Entered in the call cycle; k counts cycles after it. ret changes are sampled one edge later.
    task automatic ret_seq(input string tag, input int drop_k, input int rise_k, input int done_k,
                           input logic exp_to);
        for (int k = 1; k <= done_k + 1; k++) begin
            tick();
            chk($sformatf("%s_done_c%0d", tag, k), done, (k == done_k));
            chk($sformatf("%s_tmo_c%0d", tag, k), timeout, (k == done_k) && exp_to);
            if (k == drop_k) ret = 1'b0;
            if (k == rise_k) ret = 1'b1;
        end
        chk({tag, "_idle"}, busy, 1'b0);
        ret = 1'b1;
    endtask

    initial begin
        logic [31:0] d3 [3];
        logic [5:0]  a3 [3];
        logic [3:0]  h3 [3];
        d3 = '{32'hA1, 32'hA2, 32'hA3};
        a3 = '{6'd1, 6'd2, 6'd3};
        h3 = '{4'd0, 4'd1, 4'd1};

        rst_n          = 1'b0;
        start          = 1'b0;
        ret            = 1'b1;
        hif.host_valid = 1'b0;
        hif.host_data  = '0;
        hif.host_addr  = '0;
        hif.host_hops  = '0;

        // Reset state
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_fill", fill, 5'd0);
        chk("rst_call", call, 1'b0);
        chk("rst_en",   instr_en_out, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", hif.host_ready, 1'b1);

        // Three-word batch with a normal ret handshake
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_word(d3[i], a3[i], h3[i]);
        chk("b3_fill", fill, 5'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b3_busy", busy, 1'b1);
        chk("b3_en_t", instr_en_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_word($sformatf("b3_w%0d", i), d3[i], a3[i], h3[i]);
        end
        tick();
        expect_call("b3");
        ret_seq("b3", 2, 5, 6, 1'b0);

        // Sixteen words fill the FIFO; a seventeenth is refused
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("f16_ready%0d", i), hif.host_ready, 1'b1);
            push_word(32'h100 + i, 6'(i), 4'(i));
        end
        chk("f16_ready_full", hif.host_ready, 1'b0);
        chk("f16_fill", fill, 5'd16);
        push_word(32'hDEAD, 6'h3F, 4'hF);
        chk("f16_fill_17", fill, 5'd16);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_word($sformatf("f16_w%0d", i), 32'h100 + i, 6'(i), 4'(i));
        end
        tick();
        expect_call("f16");
        chk("f16_fill_end", fill, 5'd0);

        // ret held high: timeout RET_TIMEOUT+1 cycles after call
        ret_seq("tmo", 0, 0, RET_TIMEOUT + 1, 1'b1);

        // Empty-FIFO start goes straight to call
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e0_en_t", instr_en_out, 1'b0);
        chk("e0_call_t", call, 1'b0);
        tick();
        expect_call("e0");
        ret_seq("e0", 1, 2, 3, 1'b0);

        // Push coincident with start joins the batch; start mid-SEND is ignored
        push_word(32'h55, 6'd5, 4'd2);
        hif.host_valid = 1'b1;
        hif.host_data  = 32'h66;
        hif.host_addr  = 6'd6;
        hif.host_hops  = 4'd3;
        start          = 1'b1;
        tick();
        hif.host_valid = 1'b0;
        start          = 1'b0;
        chk("vs_fill", fill, 5'd2);
        tick();
        expect_word("vs_w0", 32'h55, 6'd5, 4'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_word("vs_w1", 32'h66, 6'd6, 4'd3);
        tick();
        expect_call("vs");
        ret_seq("vs", 1, 2, 3, 1'b0);
        tick();
        chk("vs_norelaunch_call", call, 1'b0);
        chk("vs_norelaunch_busy", busy, 1'b0);

        // Reset during the second of four SEND cycles
        for (int i = 0; i < 4; i++) push_word(32'h31 + i, 6'(i), 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_word("rs_w0", 32'h31, 6'd0, 4'd1);
        tick();
        expect_word("rs_w1", 32'h32, 6'd1, 4'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_en",   instr_en_out, 1'b0);
        chk("rs_data", instr_data_out, 32'h0);
        chk("rs_call", call, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_fill", fill, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_fill_rel", fill, 5'd0);
        chk("rs_ready_rel", hif.host_ready, 1'b1);
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_en_t", instr_en_out, 1'b0);
        tick();
        expect_call("rs");
        ret_seq("rs", 1, 2, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Row-level instruction transmitter feeding one row of the fabric's instruction chain and call/ret handshake. Host logic pushes {data, addr, hops} instruction words into an internal FIFO. On `start` the block streams the buffered words onto the row's `instr_*` inputs, one per cycle. It then issues `call` and tracks `ret` until the row reports completion.

## Interface
- INSTR_DATA_WIDTH, 32, instruction payload width
- INSTR_ADDR_WIDTH, 6, instruction address width
- INSTR_HOPS_WIDTH, 4, hop-count width
- FIFO_DEPTH, 16, buffered instructions; power of two, ≥2
- RET_TIMEOUT, 15, max cycles to wait for `ret` to drop after `call`; ≥1

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- host_valid  in  1  host word valid
- host_ready  out  1  block accepts the host word
- host_data  in  INSTR_DATA_WIDTH  instruction payload
- host_addr  in  INSTR_ADDR_WIDTH  target address
- host_hops  in  INSTR_HOPS_WIDTH  hop count, forwarded unchanged
- start  in  1  one-cycle launch request
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- timeout  out  1  one-cycle pulse, coincident with `done`, when `ret` never dropped
- fill  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- instr_data_out  out  INSTR_DATA_WIDTH  to row instr_data_in
- instr_addr_out  out  INSTR_ADDR_WIDTH  to row instr_addr_in
- instr_hops_out  out  INSTR_HOPS_WIDTH  to row instr_hops_in
- instr_en_out  out  1  to row instr_en_in
- call  out  1  to row call
- ret  in  1  from row ret; idles high

## Operation
- States and transitions:
  - IDLE: accepts host words. `host_ready` = IDLE && !full; a push happens when valid && ready. `start` moves to SEND if the FIFO is non-empty, otherwise to CALL.
  - SEND: pops one word per cycle and drives it with `instr_en_out`=1. After the pop that empties the FIFO, moves to CALL.
  - CALL: `call`=1 for exactly one cycle, then WAIT_BUSY; the timer clears.
  - WAIT_BUSY: while `ret`=1 the timer increments. `ret`=0 moves to WAIT_DONE. If the timer reaches RET_TIMEOUT with `ret` still 1, emits `done`+`timeout` and returns to IDLE.
  - WAIT_DONE: `ret`=1 emits `done` and returns to IDLE.
- `start` is ignored outside IDLE. `host_ready`=0 outside IDLE, so the batch is frozen once launched.
- `host_valid` && `start` in the same IDLE cycle: the word is pushed and is included in the batch.
- FIFO full: `host_ready`=0 and no overwrite. Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
- When `instr_en_out`=0, `instr_data_out`, `instr_addr_out` and `instr_hops_out` are 0.
- Reset (asynchronous, at any time including mid-SEND or WAIT_*):
  - FIFO is emptied and the state returns to IDLE.
  - `call`, `instr_*`, `done`, `timeout` = 0; `busy` = 0; `fill` = 0.
  - `host_ready` = 1 once `rst_n` is high.

## Timing
- All outputs are registered except `host_ready` and `busy`, which decode the current state and FIFO flags.
- Batch of N≥1 words, with `start` sampled at edge t:
  - `instr_en_out`=1 on cycles t+1 … t+N, in FIFO order with no gaps.
  - `call`=1 on cycle t+N+1.
  - `ret` is sampled from cycle t+N+2 onward.
- N=0: `call`=1 on cycle t+1.
- `done` is high the cycle after `ret` is seen rising in WAIT_DONE.
- With no `ret` drop, `done`/`timeout` are high RET_TIMEOUT+1 cycles after `call`.
- The earliest next `start` is accepted the cycle after `done`.
- `fill` updates the cycle after each push or pop.

## Structure
- Width defaults come from `fabric_pkg` (INSTR_DATA_WIDTH, INSTR_ADDR_WIDTH, INSTR_HOPS_WIDTH) so the block matches the fabric row.
- The state enum (IDLE, SEND, CALL, WAIT_BUSY, WAIT_DONE) and the packed instruction struct {data, addr, hops} go in a new `instr_loader_pkg`.
- One sub-module, `instr_fifo`: a synchronous single-clock FIFO of the packed struct, with push, pop, full, empty and count ports.
- The FSM and timeout counter stay in `instr_loader`.

## Test plan
- Reset then push 3 words (data 0xA1/0xA2/0xA3, addr 1/2/3, hops 0/1/1), then `start`:
  - `instr_en_out` high 3 consecutive cycles carrying the words in order.
  - `call` pulses the next cycle.
  - `ret` model drops 2 cycles later and rises 5 cycles later → single `done`, `timeout`=0.
- Push 16 words: `host_ready` falls after the 16th and `fill`=16. A 17th `host_valid` is not accepted; all 16 words are emitted on `start`.
- `start` with an empty FIFO: `call` on t+1 with no `instr_en_out`.
- `ret` held at 1: `done`=`timeout`=1 exactly RET_TIMEOUT+1 cycles after `call`, then IDLE.
- `host_valid` and `start` in the same cycle with 1 word already buffered: 2 words emitted. A `start` pulsed mid-SEND is ignored.
- Assert `rst_n`=0 during the 2nd of 4 SEND cycles: `instr_en_out` and `call` are 0 immediately. After release `fill`=0; a fresh `start` issues `call` only.
